// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: loads a cook time, counts it down in seconds and
// duty-cycles the magnetron per power level, with door interlock and button handling.
module cook_sequencer #(
    parameter int unsigned CLK_PER_TICK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       load,
    input  logic [7:0] time_in,
    input  logic [3:0] power_level,
    output logic       mag_on,
    output logic [7:0] time_left,
    output logic [2:0] state_o,
    output logic       done
);

    localparam int unsigned PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_TICK - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StCook  = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    time_q, time_d;
    logic [3:0]    pwr_q, pwr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    phase_q, phase_d;
    logic          done_q, done_d;
    logic          start_s_q, stop_s_q, clear_s_q;

    logic start_press, stop_press, clear_press, tick, stop_acts;

    // A press is a 1 -> 0 transition relative to the previous sample.
    assign start_press = start_s_q & ~startn;
    assign stop_press  = stop_s_q & ~stopn;
    assign clear_press = clear_s_q & ~clearn;
    assign tick        = (presc_q == PRESC_MAX);
    assign stop_acts   = stop_press &&
                         (state_q == StCook || state_q == StPause || state_q == StDone);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pwr_d   = pwr_q;
        presc_d = presc_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        if (clear_press) begin
            state_d = StIdle;
            time_d  = 8'd0;
        end else if (stop_acts) begin
            if (state_q == StCook) begin
                state_d = StPause;
            end else begin
                if (state_q == StPause) begin
                    time_d = 8'd0;
                end
                state_d = StIdle;
            end
        end else if (state_q == StCook) begin
            // Start and load are ignored while cooking, so this branch owns COOK.
            if (!door_closed) begin
                state_d = StPause;
            end else if (tick) begin
                presc_d = '0;
                if (phase_q == 4'd9) begin
                    phase_d = 4'd0;
                    if (time_q == 8'd1) begin
                        time_d  = 8'd0;
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        time_d = time_q - 8'd1;
                    end
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (start_press && door_closed &&
                     (state_q == StSet || state_q == StPause)) begin
            state_d = StCook;
            if (state_q == StSet) begin
                pwr_d   = (power_level > 4'd10) ? 4'd10 : power_level;
                presc_d = '0;
                phase_d = 4'd0;
            end
        end else if (load && state_q != StPause) begin
            if (time_in != 8'd0) begin
                time_d  = time_in;
                state_d = StSet;
            end else begin
                time_d  = 8'd0;
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            time_q    <= 8'd0;
            pwr_q     <= 4'd0;
            presc_q   <= '0;
            phase_q   <= 4'd0;
            done_q    <= 1'b0;
            start_s_q <= 1'b1;
            stop_s_q  <= 1'b1;
            clear_s_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pwr_q     <= pwr_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            done_q    <= done_d;
            start_s_q <= startn;
            stop_s_q  <= stopn;
            clear_s_q <= clearn;
        end
    end

    assign mag_on    = (state_q == StCook) & door_closed & (phase_q < pwr_q);
    assign time_left = time_q;
    assign state_o   = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Bench for cook_sequencer: directed scenarios plus random stimulus, all checked
// cycle by cycle against an elapsed-time reference model.
module tb_cook_sequencer;

    localparam int unsigned CPT = 2;
    localparam int SEC = 10 * CPT;
    localparam int IDLE = 0, SET = 1, COOK = 2, PAUSE = 3, DONE = 4;

    logic       clk = 1'b0;
    logic       rst, startn, stopn, clearn, door_closed, load;
    logic [7:0] time_in;
    logic [3:0] power_level;
    logic       mag_on, done;
    logic [7:0] time_left;
    logic [2:0] state_o;

    int total = 0;
    int bad = 0;
    int mag_cnt, done_cnt;

    // Reference model: cook progress is tracked as elapsed cycles within the second.
    int m_state, m_time, m_pwr, m_el;
    bit m_done, m_sb, m_pb, m_cb;

    cook_sequencer #(.CLK_PER_TICK(CPT)) dut (
        .clk(clk), .rst(rst), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .load(load), .time_in(time_in),
        .power_level(power_level), .mag_on(mag_on), .time_left(time_left),
        .state_o(state_o), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_time = 0; m_pwr = 0; m_el = 0;
        m_done = 0; m_sb = 1; m_pb = 1; m_cb = 1;
    endtask

    function automatic bit exp_mag();
        return (m_state == COOK) && door_closed && (m_el < m_pwr * int'(CPT));
    endfunction

    task automatic model_step();
        bit st, sp, cl;
        st = m_sb && !startn;
        sp = m_pb && !stopn;
        cl = m_cb && !clearn;
        m_sb = startn; m_pb = stopn; m_cb = clearn;
        m_done = 0;
        if (cl) begin
            m_state = IDLE; m_time = 0;
        end else if (sp && (m_state == COOK || m_state == PAUSE || m_state == DONE)) begin
            if (m_state == COOK) m_state = PAUSE;
            else begin
                if (m_state == PAUSE) m_time = 0;
                m_state = IDLE;
            end
        end else if (m_state == COOK && !door_closed) begin
            m_state = PAUSE;
        end else if (m_state == COOK) begin
            if (m_el == SEC - 1) begin
                m_el = 0;
                m_time--;
                if (m_time == 0) begin m_state = DONE; m_done = 1; end
            end else m_el++;
        end else if (st && door_closed && (m_state == SET || m_state == PAUSE)) begin
            if (m_state == SET) begin
                m_pwr = (power_level > 10) ? 10 : int'(power_level);
                m_el = 0;
            end
            m_state = COOK;
        end else if (load && m_state != PAUSE) begin
            if (time_in != 0) begin m_time = time_in; m_state = SET; end
            else begin m_time = 0; m_state = IDLE; end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, resume just after the edge.
    task automatic cyc();
        @(negedge clk);
        chk("state", state_o, m_state);
        chk("time_left", time_left, m_time);
        chk("mag_on", mag_on, exp_mag());
        chk("done", done, m_done);
        if (mag_on) mag_cnt++;
        if (done) done_cnt++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int t);
        load = 1; time_in = 8'(t); cyc(); load = 0;
    endtask
    task automatic press_start(); startn = 0; cyc(); startn = 1; endtask
    task automatic press_stop();  stopn  = 0; cyc(); stopn  = 1; endtask
    task automatic press_clear(); clearn = 0; cyc(); clearn = 1; endtask

    task automatic run_until(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && int'(state_o) != target; i++) cyc();
        chk(tag, state_o, target);
    endtask

    initial begin
        rst = 1; startn = 1; stopn = 1; clearn = 1; door_closed = 1; load = 0;
        time_in = 0; power_level = 0; mag_cnt = 0; done_cnt = 0;
        model_reset();
        #2;
        chk("rst_state", state_o, IDLE);
        chk("rst_time", time_left, 0);
        chk("rst_mag", mag_on, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 0;

        // Full-power cook
        power_level = 10;
        do_load(3);
        press_start();
        mag_cnt = 0; done_cnt = 0;
        run_until(DONE, 200, "full_reach_done");
        cyc();
        chk("full_mag_cycles", mag_cnt, 60);
        chk("full_done_pulses", done_cnt, 1);

        // Partial power
        power_level = 3;
        do_load(2);
        press_start();
        mag_cnt = 0; done_cnt = 0;
        run_until(DONE, 200, "part_reach_done");
        cyc();
        chk("part_mag_cycles", mag_cnt, 12);
        chk("part_done_pulses", done_cnt, 1);

        // Door interlock
        power_level = 5;
        do_load(3);
        press_start();
        mag_cnt = 0;
        repeat (7) cyc();
        door_closed = 0;
        #1;
        chk("door_mag_drop", mag_on, 0);
        cyc();
        chk("door_pause", state_o, PAUSE);
        repeat (3) cyc();
        door_closed = 1;
        press_start();
        run_until(DONE, 200, "door_reach_done");
        chk("door_mag_total", mag_cnt, 30);

        // Stop semantics
        do_load(5);
        press_start();
        repeat (10) cyc();
        press_stop();
        chk("stop1_state", state_o, PAUSE);
        chk("stop1_time", time_left, 5);
        repeat (3) cyc();
        press_stop();
        chk("stop2_state", state_o, IDLE);
        chk("stop2_time", time_left, 0);
        do_load(4);
        door_closed = 0;
        press_start();
        chk("start_door_open", state_o, SET);
        door_closed = 1;

        // Ignored inputs
        press_clear();
        do_load(0);
        chk("load_zero", state_o, IDLE);
        do_load(3);
        press_start();
        repeat (4) cyc();
        do_load(9);
        chk("load_in_cook", time_left, 3);
        run_until(DONE, 200, "ign_reach_done");
        startn = 0;
        repeat (50) cyc();
        chk("held_start_done", state_o, DONE);
        startn = 1;
        do_load(2);
        clearn = 0; startn = 0;
        cyc();
        clearn = 1; startn = 1;
        chk("clear_beats_start", state_o, IDLE);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            startn      = ($urandom_range(0, 7) != 0);
            stopn       = ($urandom_range(0, 59) != 0);
            clearn      = ($urandom_range(0, 99) != 0);
            door_closed = ($urandom_range(0, 29) != 0);
            load        = ($urandom_range(0, 11) == 0);
            time_in     = 8'($urandom_range(0, 3));
            power_level = 4'($urandom_range(0, 15));
            cyc();
        end
        startn = 1; stopn = 1; clearn = 1; door_closed = 1; load = 0;
        cyc();

        // Async reset mid-cook
        press_clear();
        power_level = 10;
        do_load(3);
        press_start();
        repeat (5) cyc();
        chk("pre_reset_mag", mag_on, 1);
        #2 rst = 1;
        #1;
        chk("async_mag", mag_on, 0);
        chk("async_state", state_o, IDLE);
        chk("async_time", time_left, 0);
        chk("async_done", done, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cook_sequencer.md
# cook_sequencer

Clocked cooking sequencer that drives the magnetron enable for the microwave. It holds the loaded cook time and latches the power level. It counts the time down in seconds and duty-cycles the magnetron inside each second according to power level. It enforces the door interlock and implements the start/stop/clear button semantics (pause, resume, cancel).

## Interface
- CLK_PER_TICK, default 4: clock cycles per duty tick; 10 ticks make one cook second. The default suits simulation; set it for the real clock in synthesis.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- startn  input  1  start button, active-low level
- stopn  input  1  stop button, active-low level
- clearn  input  1  clear button, active-low level
- door_closed  input  1  1 = door latched closed
- load  input  1  one-cycle pulse: load time_in as cook time
- time_in  input  8  cook time in seconds, 0..255
- power_level  input  4  0..10; values above 10 are treated as 10
- mag_on  output  1  magnetron enable
- time_left  output  8  remaining seconds
- state_o  output  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
- done  output  1  one-cycle pulse on entry to DONE

## Operation
- Button presses are edge-detected. A press is the input sampled 0 when the previous sample was 1. The button sample registers reset to 1. A held button produces exactly one press.
- Event priority within one cycle, highest first: clear, stop, door open (COOK only), timer expiry, start, load.
- **clear press:** any state goes to IDLE and time_left becomes 0.
- **load pulse:**
  - Accepted in IDLE, SET and DONE; ignored in COOK and PAUSE.
  - If time_in ≠ 0: time_left becomes time_in and the state goes to SET.
  - If time_in = 0: time_left becomes 0 and the state goes to IDLE.
- **start press:**
  - Requires door_closed = 1; ignored otherwise.
  - In SET: go to COOK. pwr_q is latched as min(power_level, 10). The prescaler and phase counter are cleared.
  - In PAUSE: go to COOK. pwr_q, prescaler and phase are retained.
  - Ignored in IDLE, COOK and DONE.
- **stop press:**
  - COOK goes to PAUSE.
  - PAUSE goes to IDLE with time_left = 0.
  - DONE goes to IDLE.
  - Ignored in IDLE and SET.
- **door_closed = 0 in COOK:** go to PAUSE with counters frozen.
- **Counters (advance only in COOK):**
  - The prescaler counts 0..CLK_PER_TICK-1. tick is asserted when prescaler = CLK_PER_TICK-1.
  - phase counts 0..9 and advances on tick.
  - A second boundary is tick with phase = 9. At a boundary, phase wraps to 0 and time_left decrements.
  - If time_left = 1 at a boundary, time_left becomes 0, the state goes to DONE and done pulses.
- **mag_on** is combinational: (state = COOK) & door_closed & (phase < pwr_q).
  - pwr_q = 0 keeps mag_on low while the timer still runs.
  - pwr_q = 10 keeps mag_on continuously high.
- **DONE:** time_left = 0 and mag_on = 0. The state is left only by clear, stop or load.

## Timing
- Reset values: state IDLE, time_left 0, pwr_q 0, prescaler 0, phase 0, mag_on 0, done 0, button sample registers 1.
- The press edge and a load pulse are acted on at the same rising edge.
- mag_on rises in the first cycle that state_o = COOK. That is one cycle after the start press cycle, if pwr_q > 0.
- Door opening drops mag_on in the same cycle, with no register delay. state_o shows PAUSE from the next edge.
- Duty pattern per second: mag_on high for the first pwr_q × CLK_PER_TICK cycles of each 10 × CLK_PER_TICK-cycle second.
- Expiry: the state goes to DONE at the edge ending the last second. mag_on is 0 in that same cycle and done is high for exactly that one cycle.
- Stop at the expiry edge: stop wins. The state goes to PAUSE and time_left stays at 1.
- Reset asserted mid-cook: all registers clear immediately and mag_on falls asynchronously.

## Test plan
- **Full-power cook:** CLK_PER_TICK=2, load time_in=3, power 10, door closed, start.
  - mag_on high for exactly 60 cycles.
  - time_left steps 3→2→1→0 every 20 cycles.
  - done pulses once and state_o ends at 4.
- **Partial power:** power 3, time 2.
  - mag_on high 6 cycles and low 14 cycles in each second, twice.
  - Then DONE.
- **Door interlock:** open the door 7 cycles into a 3 s cook.
  - mag_on low in the same cycle and state_o = 3.
  - Close the door and press start: cook resumes with the retained phase and time_left.
  - Total mag_on time equals the uninterrupted case.
- **Stop semantics:**
  - First stop during COOK gives PAUSE, with time_left held.
  - Second stop gives IDLE with time_left = 0.
  - Start with the door open in SET does nothing.
- **Ignored inputs:**
  - load with time_in=0 leaves the state in IDLE.
  - load during COOK does not change time_left.
  - startn held low for 50 cycles after DONE causes no restart.
  - Simultaneous clear + start gives IDLE.
- **Async reset:** assert rst mid-cook.
  - mag_on = 0 before the next clock edge.
  - All outputs at their reset values.
